// File: rtl/cyclic_decoder_serial.sv
// cyclic_decoder_serial
// Serial single-error-correcting decoder for the systematic (7,4) cyclic
// code, g(x) = x^3 + x + 1. Code bits arrive c6 first; the corrected
// message bits m3..m0 leave under valid/ready flow control.
// Optional feature macro: CYC_DEC_STATS_EN (saturating corrected-frame
// counter on corr_cnt; tied to 0 when undefined).
module cyclic_decoder_serial #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic             out_err,
    input  logic             out_ready,
    output logic [CNT_W-1:0] corr_cnt
);

    logic [2:0] bit_cnt;
    logic [6:0] frame;
    logic [2:0] syn;
    logic       frame_done;
    logic [3:0] out_sr;
    logic [2:0] out_rem;
    logic       err_q;

    logic       accept;
    logic       take;
    logic       load;
    logic [2:0] syn_base;
    logic [2:0] syn_next;
    logic [3:0] flip;
    logic [3:0] data_fix;

    assign in_ready  = !frame_done;
    assign accept    = in_valid && in_ready;
    assign out_valid = (out_rem != 3'd0);
    assign take      = out_valid && out_ready;
    assign out_bit   = out_sr[3];
    assign out_last  = (out_rem == 3'd1);
    assign out_err   = err_q;

    // The output stage may take a new frame when empty or when its last
    // bit leaves this very cycle, so frames follow each other without a bubble.
    assign load = frame_done && ((out_rem == 3'd0) || ((out_rem == 3'd1) && out_ready));

    // Syndrome LFSR step; the first bit of a frame starts from zero.
    always_comb begin
        syn_base = (bit_cnt == 3'd0) ? 3'b000 : syn;
        syn_next = {syn_base[1], syn_base[0] ^ syn_base[2], in_bit ^ syn_base[2]};
    end

    // Map syndrome to a flipped data bit; parity positions leave data untouched.
    always_comb begin
        flip = 4'b0000;
        case (syn)
            3'b101:  flip = 4'b1000;
            3'b111:  flip = 4'b0100;
            3'b110:  flip = 4'b0010;
            3'b011:  flip = 4'b0001;
            default: flip = 4'b0000;
        endcase
        data_fix = frame[6:3] ^ flip;
    end

    // Input stage: shift in accepted bits, track position, flag a complete frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            frame      <= '0;
            syn        <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            frame <= {frame[5:0], in_bit};
            syn   <= syn_next;
            if (bit_cnt == 3'd6) begin
                bit_cnt    <= '0;
                frame_done <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else if (load) begin
            frame_done <= 1'b0;
            syn        <= '0;
        end
    end

    // Output stage: load corrected data, then shift one bit per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sr  <= '0;
            out_rem <= '0;
            err_q   <= 1'b0;
        end else if (load) begin
            out_sr  <= data_fix;
            out_rem <= 3'd4;
            err_q   <= (syn != 3'b000);
        end else if (take) begin
            out_sr  <= {out_sr[2:0], 1'b0};
            out_rem <= out_rem - 3'd1;
        end
    end

`ifdef CYC_DEC_STATS_EN
    logic [CNT_W-1:0] corr_q;

    // Count loaded frames with a nonzero syndrome, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_q <= '0;
        end else if (load && (syn != 3'b000) && (corr_q != '1)) begin
            corr_q <= corr_q + 1'b1;
        end
    end

    assign corr_cnt = corr_q;
`else
    assign corr_cnt = '0;
`endif

endmodule

// File: tb/tb_cyclic_decoder_serial.sv
// Testbench for cyclic_decoder_serial: directed scenarios followed by
// randomized frames, checked against a polynomial-division reference model.
module tb_cyclic_decoder_serial;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;
    logic             out_err;
    logic             out_ready;
    logic [CNT_W-1:0] corr_cnt;

    cyclic_decoder_serial #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_ready (out_ready),
        .corr_cnt  (corr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
        logic err;
    } exp_t;

    exp_t expq[$];
    logic rxq[$];
    logic txq[$];
    int   err_frames;
    int   n_assert;
    int   n_fail;

    // Remainder of r(x) divided by x^3 + x + 1, by long division.
    function automatic logic [2:0] poly_mod(input logic [6:0] r);
        logic [6:0] t;
        logic [6:0] g;
        t = r;
        g = 7'b0001011;
        for (int i = 6; i >= 3; i--)
            if (t[i]) t = t ^ (g << (i - 3));
        return t[2:0];
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] m);
        logic [6:0] c;
        c = {m, 3'b000};
        return {m, poly_mod(c)};
    endfunction

    // Decode a full received word and queue the expected output bits.
    function automatic void model_frame(input logic [6:0] r);
        logic [2:0] s;
        logic [6:0] fixed;
        logic [6:0] one;
        exp_t       e;
        s     = poly_mod(r);
        fixed = r;
        one   = 7'd1;
        if (s != 3'b000) begin
            err_frames++;
            for (int p = 0; p < 7; p++)
                if (poly_mod(one << p) == s) fixed[p] = ~fixed[p];
        end
        for (int k = 0; k < 4; k++) begin
            e.b    = fixed[6 - k];
            e.last = (k == 3);
            e.err  = (s != 3'b000);
            expq.push_back(e);
        end
    endfunction

    function automatic int exp_corr();
`ifdef CYC_DEC_STATS_EN
        return (err_frames > 3) ? 3 : err_frames;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check any output handshake, advance, update model.
    task automatic tick(input logic v, input logic b, input logic r);
        logic acc;
        logic tk;
        exp_t e;
        logic [6:0] word;
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        acc = v && in_ready;
        tk  = out_valid && r;
        if (tk) begin
            chk("out_expected", 32'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_bit", 32'(out_bit), 32'(e.b));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            rxq.push_back(b);
            if (rxq.size() == 7) begin
                for (int k = 0; k < 7; k++) word[6 - k] = rxq[k];
                rxq.delete();
                model_frame(word);
            end
        end
    endtask

    task automatic send_frame(input logic [6:0] c, input logic r);
        for (int i = 6; i >= 0; i--) begin
            int guard;
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick(1'b0, 1'b0, r);
                guard++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
            tick(1'b1, c[i], r);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((expq.size() != 0 || out_valid) && g < 200) begin
            tick(1'b0, 1'b0, 1'b1);
            g++;
        end
        chk("drain_queue", 32'(expq.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        err_frames = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bit", 32'(out_bit), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_corr_cnt", 32'(corr_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean frame, with latency of the first output bit.
        send_frame(7'b1011000, 1'b1);
        chk("lat_valid_n", 32'(out_valid), 0);
        chk("lat_ready_n", 32'(in_ready), 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("lat_valid_n1", 32'(out_valid), 1);
        chk("lat_bit_n1", 32'(out_bit), 1);
        chk("lat_ready_n1", 32'(in_ready), 1);
        drain();

        // Single data error (c6) and single parity error (c0).
        send_frame(7'b0000101, 1'b1);
        drain();
        send_frame(7'b1011001, 1'b1);
        drain();
        chk("corr_after_2", 32'(corr_cnt), 32'(exp_corr()));

        // Backpressure: two frames queued while downstream stalls.
        send_frame(7'b1011000, 1'b0);
        send_frame(7'b1000101, 1'b0);
        chk("bp_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            tick(1'b1, 1'b1, 1'b0);
        end
        drain();

        // Back-to-back frames with downstream always ready.
        send_frame(7'b1100010, 1'b1);
        send_frame(7'b0110100, 1'b1);
        send_frame(7'b1111111, 1'b1);
        drain();

        // Four more erroneous frames push the counter to saturation.
        send_frame(7'b1000100, 1'b1);
        send_frame(7'b0011000, 1'b1);
        send_frame(7'b1111110, 1'b1);
        send_frame(7'b0000001, 1'b1);
        drain();
        chk("corr_sat", 32'(corr_cnt), 32'(exp_corr()));

        // Reset in the middle of a frame.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_corr", 32'(corr_cnt), 0);
        rxq.delete();
        expq.delete();
        err_frames = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(7'b1000101, 1'b1);
        drain();

        // Randomized traffic with random valid/ready gaps.
        for (int f = 0; f < 40; f++) begin
            logic [6:0] c;
            c = encode(4'($urandom));
            if ($urandom_range(0, 2) != 0) c[$urandom_range(0, 6)] ^= 1'b1;
            for (int i = 6; i >= 0; i--) txq.push_back(c[i]);
        end
        begin
            int g;
            g = 0;
            while (txq.size() > 0 && g < 5000) begin
                logic v;
                logic b;
                logic r;
                logic acc;
                v   = ($urandom_range(0, 3) != 0);
                b   = v ? txq[0] : 1'($urandom);
                r   = ($urandom_range(0, 2) != 0);
                acc = v && in_ready;
                tick(v, b, r);
                if (acc) void'(txq.pop_front());
                g++;
            end
            chk("rand_tx_done", 32'(txq.size()), 0);
        end
        drain();
        chk("rand_corr", 32'(corr_cnt), 32'(exp_corr()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
